lpc_host_tx: RTL and testbench

LPC host-side cycle generator, the initiator counterpart to the lpc sniffer/decoder. Takes one request at a time from a local valid/ready port and drives the LPC frame sequence: START, CYCTYPE/DIR, address, write data, TAR, SYNC wait, read data, TAR. It then returns a one-cycle response. It drives the bus through a split in/out/oe nibble interface; the tristate buffer sits at the top level.

---
 rtl/lpc_pkg.sv | 43 ++++
 rtl/lpc_sync_watch.sv | 51 +++++
 rtl/lpc_host_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_lpc_host_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC host encodings: cycle types, SYNC codes, LAD constants and FSM states.
package lpc_pkg;

    localparam logic [3:0] CYCTYPE_IO_RD  = 4'b0000;
    localparam logic [3:0] CYCTYPE_IO_WR  = 4'b0010;
    localparam logic [3:0] CYCTYPE_MEM_RD = 4'b0100;
    localparam logic [3:0] CYCTYPE_MEM_WR = 4'b0110;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    localparam logic [3:0] LAD_START = 4'b0000;
    localparam logic [3:0] LAD_ABORT = 4'b1111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CTDIR,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR1,
        ST_HTAR2,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR,
        ST_ABORT,
        ST_ABEND
    } lpc_state_e;

    function automatic logic cyctype_supported(input logic [3:0] c);
        return (c == CYCTYPE_IO_RD) || (c == CYCTYPE_IO_WR) ||
               (c == CYCTYPE_MEM_RD) || (c == CYCTYPE_MEM_WR);
    endfunction

    function automatic logic [3:0] addr_nibble(input logic [31:0] addr, input logic [2:0] idx);
        logic [4:0] lsb;
        lsb = {idx, 2'b00};
        return addr[lsb +: 4];
    endfunction

endpackage

// File: rtl/lpc_sync_watch.sv
// Decodes the SYNC nibble and tracks how long the peripheral has kept the host waiting.
module lpc_sync_watch
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT  = 8,
    parameter int unsigned LWAIT_TIMEOUT = 1024
) (
    input  logic       lpc_clock,
    input  logic       lpc_reset,
    input  logic       active,
    input  logic [3:0] ad_in,
    output logic       ready_c,
    output logic       error_c,
    output logic       abort_c
);

    localparam int unsigned CNT_W = $clog2(LWAIT_TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, limit;
    logic             waiting;

    // Wait counter is held at zero outside SYNC so every SYNC phase starts fresh.
    always_comb begin
        ready_c = active && (ad_in == SYNC_READY);
        error_c = active && (ad_in == SYNC_ERROR);
        waiting = active && !ready_c && !error_c;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        case (ad_in)
            SYNC_LWAIT: limit = CNT_W'(LWAIT_TIMEOUT);
            SYNC_SWAIT: limit = CNT_W'(SYNC_TIMEOUT);
            default:    limit = CNT_W'(SYNC_TIMEOUT);
        endcase
        abort_c = waiting && (cnt_inc >= limit);
        if (!active) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lpc_host_tx.sv
// LPC host cycle generator: one local request in, one LPC frame out, one response pulse back.
module lpc_host_tx
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT  = 8,
    parameter int unsigned LWAIT_TIMEOUT = 1024
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_error,
    input  logic [3:0]  lpc_ad_in,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    output logic        lpc_frame
);

    lpc_state_e  state_q, state_d;
    logic [2:0]  nib_q, nib_d;
    logic [3:0]  cyc_q, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        frame_q, frame_d;
    logic        oe_q, oe_d;
    logic [3:0]  ad_q, ad_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;

    logic        sync_active_c, sync_ready_c, sync_error_c, sync_abort_c;
    logic        is_mem, is_wr;
    logic [2:0]  addr_last;

    assign sync_active_c = (state_q == ST_SYNC);
    assign is_mem        = cyc_q[2];
    assign is_wr         = cyc_q[1];
    assign addr_last     = is_mem ? 3'd7 : 3'd3;

    lpc_sync_watch #(
        .SYNC_TIMEOUT  (SYNC_TIMEOUT),
        .LWAIT_TIMEOUT (LWAIT_TIMEOUT)
    ) u_sync_watch (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .active    (sync_active_c),
        .ad_in     (lpc_ad_in),
        .ready_c   (sync_ready_c),
        .error_c   (sync_error_c),
        .abort_c   (sync_abort_c)
    );

    always_comb begin
        state_d     = state_q;
        nib_d       = nib_q;
        cyc_d       = cyc_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 8'h00;
        rsp_error_d = 1'b0;
        frame_d     = 1'b1;
        oe_d        = 1'b0;
        ad_d        = LAD_ABORT;
        ready_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    cyc_d   = req_cyctype_dir;
                    addr_d  = req_addr;
                    wdata_d = req_data;
                    rdata_d = 8'h00;
                    err_d   = 1'b0;
                    nib_d   = 3'd0;
                    if (cyctype_supported(req_cyctype_dir)) begin
                        state_d = ST_START;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
            end
            ST_START: state_d = ST_CTDIR;
            ST_CTDIR: begin
                state_d = ST_ADDR;
                nib_d   = 3'd0;
            end
            ST_ADDR: begin
                if (nib_q == addr_last) begin
                    state_d = is_wr ? ST_WDATA : ST_HTAR1;
                    nib_d   = 3'd0;
                end else begin
                    nib_d = nib_q + 3'd1;
                end
            end
            ST_WDATA: begin
                if (nib_q[0]) begin
                    state_d = ST_HTAR1;
                end
                nib_d = 3'd1;
            end
            ST_HTAR1: state_d = ST_HTAR2;
            ST_HTAR2: state_d = ST_SYNC;
            ST_SYNC: begin
                if (sync_ready_c || sync_error_c) begin
                    err_d   = sync_error_c;
                    nib_d   = 3'd0;
                    state_d = is_wr ? ST_PTAR : ST_RDATA;
                end else if (sync_abort_c) begin
                    nib_d   = 3'd0;
                    state_d = ST_ABORT;
                end
            end
            ST_RDATA: begin
                if (nib_q[0]) begin
                    rdata_d[7:4] = lpc_ad_in;
                    nib_d        = 3'd0;
                    state_d      = ST_PTAR;
                end else begin
                    rdata_d[3:0] = lpc_ad_in;
                    nib_d        = 3'd1;
                end
            end
            ST_PTAR: begin
                if (nib_q[0]) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = is_wr ? 8'h00 : rdata_q;
                    rsp_error_d = err_q;
                end
                nib_d = 3'd1;
            end
            ST_ABORT: begin
                if (nib_q == 3'd3) begin
                    state_d = ST_ABEND;
                end
                nib_d = nib_q + 3'd1;
            end
            ST_ABEND: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus pins are registered, so they are decoded from the state being entered.
        case (state_d)
            ST_IDLE:  ready_d = 1'b1;
            ST_START: begin
                frame_d = 1'b0;
                oe_d    = 1'b1;
                ad_d    = LAD_START;
            end
            ST_CTDIR: begin
                oe_d = 1'b1;
                ad_d = cyc_d;
            end
            ST_ADDR: begin
                oe_d = 1'b1;
                ad_d = addr_nibble(addr_d, cyc_d[2] ? 3'(3'd7 - nib_d) : 3'(3'd3 - nib_d));
            end
            ST_WDATA: begin
                oe_d = 1'b1;
                ad_d = nib_d[0] ? wdata_d[7:4] : wdata_d[3:0];
            end
            ST_HTAR1: oe_d = 1'b1;
            ST_ABORT: begin
                frame_d = 1'b0;
                oe_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q     <= ST_IDLE;
            nib_q       <= 3'd0;
            cyc_q       <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            frame_q     <= 1'b1;
            oe_q        <= 1'b0;
            ad_q        <= LAD_ABORT;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            cyc_q       <= cyc_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            oe_q        <= oe_d;
            ad_q        <= ad_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign lpc_ad_out = ad_q;
    assign lpc_ad_oe  = oe_q;
    assign lpc_frame  = frame_q;

endmodule

// File: tb/tb_lpc_host_tx.sv
// Bench for lpc_host_tx: per-cycle expected bus/response schedule built from the LPC frame rules.
module tb_lpc_host_tx;

    localparam int unsigned ST = 8;
    localparam int unsigned LW = 1024;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [7:0]  req_data = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic [3:0]  lpc_ad_in = 4'hF;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic        lpc_frame;

    always #5 lpc_clock = ~lpc_clock;

    lpc_host_tx #(.SYNC_TIMEOUT(ST), .LWAIT_TIMEOUT(LW)) dut (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cyctype_dir (req_cyctype_dir),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .lpc_ad_in       (lpc_ad_in),
        .lpc_ad_out      (lpc_ad_out),
        .lpc_ad_oe       (lpc_ad_oe),
        .lpc_frame       (lpc_frame)
    );

    // One bus cycle: what the DUT must show, and what the bench drives.
    typedef struct {
        logic        e_frame;
        logic        e_oe;
        logic [3:0]  e_ad;
        logic        e_ready;
        logic        e_rv;
        logic [7:0]  e_rdata;
        logic        e_rerr;
        logic        d_valid;
        logic [3:0]  d_cyc;
        logic [31:0] d_addr;
        logic [7:0]  d_data;
        logic [3:0]  d_ad;
    } rec_t;

    rec_t        sched[$];
    rec_t        cur;
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    logic [63:0] obs_val;
    int          obs_cnt, obs_flow, t_start, t_rsp;
    logic        seen_start, obs_rerr;
    logic [7:0]  obs_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r.e_frame = 1'b1; r.e_oe = 1'b0; r.e_ad = 4'hF; r.e_ready = 1'b1;
        r.e_rv = 1'b0; r.e_rdata = 8'h00; r.e_rerr = 1'b0;
        r.d_valid = 1'b0; r.d_cyc = 4'($urandom); r.d_addr = $urandom;
        r.d_data = 8'($urandom); r.d_ad = 4'($urandom);
        return r;
    endfunction

    function automatic rec_t busy(input logic f, input logic oe, input logic [3:0] ad);
        rec_t r;
        r = idle_rec();
        r.e_frame = f; r.e_oe = oe; r.e_ad = ad; r.e_ready = 1'b0;
        r.d_valid = 1'($urandom);
        return r;
    endfunction

    // Append one request's cycles; merge puts the accept on the previous response cycle.
    task automatic add_txn(input logic [3:0] cyc, input logic [31:0] addr, input logic [7:0] data,
                           input logic [3:0] script[$], input logic [7:0] rd, input bit merge);
        rec_t       r;
        logic [7:0] exp_d;
        logic       exp_e;
        int         n, cnt, lim;
        bit         wr, ab;
        logic [3:0] term;
        if (merge && sched.size() > 0) r = sched.pop_back();
        else r = idle_rec();
        r.d_valid = 1'b1; r.d_cyc = cyc; r.d_addr = addr; r.d_data = data;
        sched.push_back(r);
        exp_d = 8'h00;
        exp_e = 1'b1;
        if (cyc[3] == 1'b0 && cyc[0] == 1'b0) begin
            n  = cyc[2] ? 8 : 4;
            wr = cyc[1];
            sched.push_back(busy(1'b0, 1'b1, 4'h0));
            sched.push_back(busy(1'b1, 1'b1, cyc));
            for (int i = 0; i < n; i++)
                sched.push_back(busy(1'b1, 1'b1, 4'(addr >> (4 * (n - 1 - i)))));
            if (wr) begin
                sched.push_back(busy(1'b1, 1'b1, data[3:0]));
                sched.push_back(busy(1'b1, 1'b1, data[7:4]));
            end
            sched.push_back(busy(1'b1, 1'b1, 4'hF));
            sched.push_back(busy(1'b1, 1'b0, 4'hF));
            cnt = 0; ab = 1'b0; term = 4'h0;
            foreach (script[k]) begin
                r = busy(1'b1, 1'b0, 4'hF);
                r.d_ad = script[k];
                sched.push_back(r);
                if (script[k] == 4'h0 || script[k] == 4'hA) begin
                    term = script[k];
                    break;
                end
                cnt++;
                lim = (script[k] == 4'h6) ? LW : ST;
                if (cnt >= lim) begin
                    ab = 1'b1;
                    break;
                end
            end
            if (ab) begin
                repeat (4) sched.push_back(busy(1'b0, 1'b1, 4'hF));
                sched.push_back(busy(1'b1, 1'b0, 4'hF));
            end else begin
                if (!wr) begin
                    r = busy(1'b1, 1'b0, 4'hF); r.d_ad = rd[3:0]; sched.push_back(r);
                    r = busy(1'b1, 1'b0, 4'hF); r.d_ad = rd[7:4]; sched.push_back(r);
                end
                repeat (2) sched.push_back(busy(1'b1, 1'b0, 4'hF));
                exp_d = wr ? 8'h00 : rd;
                exp_e = (term == 4'hA);
            end
        end
        r = idle_rec();
        r.e_rv = 1'b1; r.e_rdata = exp_d; r.e_rerr = exp_e;
        sched.push_back(r);
    endtask

    task automatic play(input int n);
        int k;
        k = 0;
        while (sched.size() > 0 && (n < 0 || k < n)) begin
            rec_t r;
            r = sched.pop_front();
            @(posedge lpc_clock);
            #1;
            req_valid       = r.d_valid;
            req_cyctype_dir = r.d_cyc;
            req_addr        = r.d_addr;
            req_data        = r.d_data;
            lpc_ad_in       = r.d_ad;
            cur             = r;
            chk_en          = 1'b1;
            k++;
        end
    endtask

    task automatic finish_play();
        @(negedge lpc_clock);
        #1;
        chk_en    = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic obs_clear();
        obs_val = 64'h0; obs_cnt = 0; obs_flow = 0; seen_start = 1'b0;
        t_start = 0; t_rsp = 0; obs_rdata = 8'h00; obs_rerr = 1'b0;
    endtask

    // Single compare process: every checked cycle is sampled on the falling edge.
    initial begin : compare
        forever begin
            @(negedge lpc_clock);
            cyc_n++;
            if (chk_en) begin
                chk("frame", 64'(lpc_frame), 64'(cur.e_frame));
                chk("ad_oe", 64'(lpc_ad_oe), 64'(cur.e_oe));
                if (cur.e_oe) chk("ad_out", 64'(lpc_ad_out), 64'(cur.e_ad));
                chk("req_ready", 64'(req_ready), 64'(cur.e_ready));
                chk("rsp_valid", 64'(rsp_valid), 64'(cur.e_rv));
                if (cur.e_rv) begin
                    chk("rsp_data", 64'(rsp_data), 64'(cur.e_rdata));
                    chk("rsp_error", 64'(rsp_error), 64'(cur.e_rerr));
                end
            end
            if (lpc_reset) begin
                if (!lpc_frame) obs_flow++;
                if (!lpc_frame && lpc_ad_oe && lpc_ad_out == 4'h0 && !seen_start) begin
                    seen_start = 1'b1;
                    t_start    = cyc_n;
                end
                if (lpc_frame && lpc_ad_oe) begin
                    obs_val = {obs_val[59:0], lpc_ad_out};
                    obs_cnt++;
                end
                if (rsp_valid) begin
                    t_rsp     = cyc_n;
                    obs_rdata = rsp_data;
                    obs_rerr  = rsp_error;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc_n);
        $fatal(1);
    end

    initial begin : main
        logic [3:0] sc[$];
        logic [3:0] v;
        logic [3:0] cyc;
        bit         merge;

        repeat (2) @(negedge lpc_clock);
        chk("rst_frame", 64'(lpc_frame), 64'h1);
        chk("rst_oe", 64'(lpc_ad_oe), 64'h0);
        chk("rst_ad", 64'(lpc_ad_out), 64'hF);
        chk("rst_ready", 64'(req_ready), 64'h1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_rsp_error", 64'(rsp_error), 64'h0);
        lpc_reset = 1'b1;

        // IO write 0x7fe5 <- 0x6c, immediate ready
        sched.push_back(idle_rec());
        sc = {4'h0};
        add_txn(4'b0010, 32'h7fe5, 8'h6c, sc, 8'h00, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("iow_nibcnt", 64'(obs_cnt), 64'd8);
        chk("iow_nibs", 64'(obs_val[31:0]), 64'h27fe5c6f);
        chk("iow_lat", 64'(t_rsp - t_start), 64'd13);
        chk("iow_err", 64'(obs_rerr), 64'h0);

        // IO read 0x002e with two short waits
        sched.push_back(idle_rec());
        sc = {4'h5, 4'h5, 4'h0};
        add_txn(4'b0000, 32'h002e, 8'h00, sc, 8'ha5, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("ior_nibs", 64'(obs_val[23:0]), 64'h0002ef);
        chk("ior_lat", 64'(t_rsp - t_start), 64'd15);
        chk("ior_data", 64'(obs_rdata), 64'ha5);
        chk("ior_err", 64'(obs_rerr), 64'h0);

        // Mem write 0xfedc0010 <- 0x3c
        sched.push_back(idle_rec());
        sc = {4'h0};
        add_txn(4'b0110, 32'hfedc0010, 8'h3c, sc, 8'h00, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("memw_nibcnt", 64'(obs_cnt), 64'd12);
        chk("memw_nibs", 64'(obs_val[47:0]), 64'h6fedc0010c3f);
        chk("memw_lat", 64'(t_rsp - t_start), 64'd17);

        // Timeout on floating LAD, then a back-to-back IO write
        sched.push_back(idle_rec());
        sc.delete();
        repeat (12) sc.push_back(4'hF);
        add_txn(4'b0000, 32'h0080, 8'h00, sc, 8'h00, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("tmo_lat", 64'(t_rsp - t_start), 64'd21);
        chk("tmo_frame_low", 64'(obs_flow), 64'd5);
        chk("tmo_err", 64'(obs_rerr), 64'h1);
        chk("tmo_data", 64'(obs_rdata), 64'h0);
        sched.push_back(idle_rec());
        sc = {4'h0};
        add_txn(4'b0000, 32'h0081, 8'h00, sc, 8'h5a, 1'b0);
        sc = {4'h0};
        add_txn(4'b0010, 32'h1234, 8'h99, sc, 8'h00, 1'b1);
        play(-1); finish_play();

        // SYNC error still consumes read data
        sched.push_back(idle_rec());
        sc = {4'hA};
        add_txn(4'b0000, 32'h0060, 8'h00, sc, 8'hff, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("serr_err", 64'(obs_rerr), 64'h1);
        chk("serr_data", 64'(obs_rdata), 64'hff);

        // Unsupported cycle type: no frame, error response
        sched.push_back(idle_rec());
        sc = {4'h0};
        add_txn(4'b1000, 32'h0060, 8'h00, sc, 8'h00, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("unsup_nostart", 64'(seen_start), 64'h0);
        chk("unsup_err", 64'(obs_rerr), 64'h1);

        // Long waits: mixed limit, long but completing, and long-wait timeout
        sched.push_back(idle_rec());
        sc.delete();
        repeat (7) sc.push_back(4'h6);
        sc.push_back(4'hF); sc.push_back(4'h0);
        add_txn(4'b0100, 32'h000f0000, 8'h00, sc, 8'h11, 1'b0);
        sc.delete();
        repeat (40) sc.push_back(4'h6);
        sc.push_back(4'h0);
        add_txn(4'b0100, 32'h000f0004, 8'h00, sc, 8'h22, 1'b0);
        sc.delete();
        repeat (LW + 2) sc.push_back(4'h6);
        add_txn(4'b0110, 32'h000f0008, 8'h77, sc, 8'h00, 1'b1);
        play(-1); finish_play();

        // Reset asserted between edges during the address phase
        sched.push_back(idle_rec());
        sc = {4'h0};
        add_txn(4'b0010, 32'h4321, 8'h55, sc, 8'h00, 1'b0);
        play(5); finish_play();
        sched.delete();
        #1;
        lpc_reset = 1'b0;
        #1;
        chk("mrst_frame", 64'(lpc_frame), 64'h1);
        chk("mrst_oe", 64'(lpc_ad_oe), 64'h0);
        @(negedge lpc_clock);
        #2;
        lpc_reset = 1'b1;
        chk("mrst_ready", 64'(req_ready), 64'h1);
        sched.push_back(idle_rec());
        sc = {4'h0};
        add_txn(4'b0010, 32'h7fe5, 8'h6c, sc, 8'h00, 1'b0);
        obs_clear(); play(-1); finish_play();
        chk("mrst_lat", 64'(t_rsp - t_start), 64'd13);

        // Randomized traffic
        sched.push_back(idle_rec());
        for (int t = 0; t < 200; t++) begin
            sc.delete();
            for (int j = 0; j < int'($urandom_range(0, 10)); j++) begin
                case ($urandom_range(0, 3))
                    0: v = 4'hF;
                    1: v = 4'h5;
                    2: v = 4'h6;
                    default: begin
                        v = 4'($urandom_range(0, 15));
                        if (v == 4'h0 || v == 4'hA) v = 4'h3;
                    end
                endcase
                sc.push_back(v);
            end
            sc.push_back(($urandom_range(0, 4) == 0) ? 4'hA : 4'h0);
            if ($urandom_range(0, 6) == 0) begin
                cyc = 4'($urandom) | 4'h1;
            end else begin
                cyc = {1'b0, 2'($urandom), 1'b0};
            end
            merge = ($urandom_range(0, 2) == 0);
            if (!merge) repeat ($urandom_range(0, 2)) sched.push_back(idle_rec());
            add_txn(cyc, $urandom, 8'($urandom), sc, 8'($urandom), merge);
        end
        play(-1); finish_play();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
